// File: rtl/pixel_write_engine.sv
// pixel_write_engine: command FIFO feeding a pixel / rectangle-fill writer for a pixel buffer.
// Define PIXEL_WRITE_ENGINE_RECT_FILL_EN to enable rectangle fill; otherwise fills act as single pixels.
module pixel_write_engine #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 4,
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int FIFO_DEPTH = 4,
    parameter int X_W        = 8,
    parameter int Y_W        = 7
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_op,
    input  logic [X_W-1:0]                cmd_x,
    input  logic [Y_W-1:0]                cmd_y,
    input  logic [X_W-1:0]                cmd_w,
    input  logic [Y_W-1:0]                cmd_h,
    input  logic [DATA_W-1:0]             cmd_color,
    output logic [ADDR_W-1:0]             pb_adr_export,
    output logic [DATA_W-1:0]             pb_data_export,
    output logic                          pbuff_wren_export,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    typedef struct packed {
        logic              op;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [X_W-1:0]    w;
        logic [Y_W-1:0]    h;
        logic [DATA_W-1:0] color;
    } cmd_t;
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, FILL} state_t;
    state_t state, state_n;
    cmd_t fifo [FIFO_DEPTH];
    cmd_t cmd_in, head;
    logic [AW-1:0] rd, wr;
    logic push, pop, emit;
    logic [X_W:0] ex;
    logic [Y_W:0] ey;
    logic [DATA_W-1:0] color;
    assign cmd_in = '{cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
    assign head = fifo[rd];
    assign cmd_ready = fifo_level != LW'(FIFO_DEPTH);
    assign busy = fifo_level != '0 || state != IDLE;
    assign push = cmd_valid && cmd_ready;
    assign pop = state == LOAD;
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
    cmd_t cur;
    logic [X_W-1:0] i, i_n;
    logic [Y_W-1:0] j, j_n;
    logic unused_op;
    assign unused_op = cur.op;
    assign color = state == LOAD ? head.color : cur.color;
    always_ff @(posedge clk_clk) begin
        i <= i_n;
        j <= j_n;
        if (state == LOAD) cur <= head;
    end
`else
    logic unused_fill;
    assign unused_fill = ^{head.op, head.w, head.h};
    assign color = head.color;
`endif
    always_ff @(posedge clk_clk) begin
        if (push && !reset_reset) fifo[wr] <= cmd_in;
    end
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rd <= '0;
            wr <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr <= wr + AW'(1);
            if (pop) rd <= rd + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end
    // ex/ey carry one extra bit so coordinates past the field width clip instead of wrapping.
    always_comb begin
        state_n = state;
        emit = 1'b0;
        ex = {1'b0, head.x};
        ey = {1'b0, head.y};
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
        i_n = i;
        j_n = j;
`endif
        case (state)
            IDLE: state_n = fifo_level != '0 ? LOAD : IDLE;
            LOAD: begin
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
                i_n = '0;
                j_n = '0;
                emit = !head.op || (head.w != '0 && head.h != '0);
                state_n = !emit ? IDLE : head.op ? FILL : WRITE;
`else
                emit = 1'b1;
                state_n = WRITE;
`endif
            end
            WRITE: state_n = fifo_level != '0 ? LOAD : IDLE;
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
            FILL: begin
                if (i + X_W'(1) != cur.w) i_n = i + X_W'(1);
                else if (j + Y_W'(1) != cur.h) begin
                    i_n = '0;
                    j_n = j + Y_W'(1);
                end else state_n = fifo_level != '0 ? LOAD : IDLE;
                emit = state_n == FILL;
                ex = {1'b0, cur.x} + {1'b0, i_n};
                ey = {1'b0, cur.y} + {1'b0, j_n};
            end
`endif
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            pbuff_wren_export <= 1'b0;
            pb_adr_export <= '0;
            pb_data_export <= '0;
        end else begin
            state <= state_n;
            pbuff_wren_export <= emit && int'(ex) < FB_W && int'(ey) < FB_H;
            if (emit) begin
                pb_adr_export <= ADDR_W'(ey) * ADDR_W'(FB_W) + ADDR_W'(ex);
                pb_data_export <= color;
            end
        end
    end
endmodule

// File: tb/tb_pixel_write_engine.sv
// tb_pixel_write_engine: vector table, directed timing sequences and a randomized run against a write-list model.
// Follows PIXEL_WRITE_ENGINE_RECT_FILL_EN the same way as the design.
module tb_pixel_write_engine;
    localparam int FB_W = 160, FB_H = 120, DEPTH = 4;
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif
    logic clk_clk = 1'b0, reset_reset = 1'b1, cmd_valid = 1'b0, cmd_op = 1'b0;
    logic [7:0] cmd_x = '0, cmd_w = '0;
    logic [6:0] cmd_y = '0, cmd_h = '0;
    logic [3:0] cmd_color = '0;
    logic cmd_ready, pbuff_wren_export, busy;
    logic [14:0] pb_adr_export;
    logic [3:0] pb_data_export;
    logic [2:0] fifo_level;

    pixel_write_engine dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .pb_adr_export(pb_adr_export), .pb_data_export(pb_data_export),
        .pbuff_wren_export(pbuff_wren_export), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {int adr; int data; int cyc;} wr_t;
    typedef struct {int adr; int data;} ex_t;
    typedef struct {bit op; int x, y, w, h, c, n, first, last;} vec_t;
    wr_t wq[$];
    ex_t eq[$];
    int cyc = 0, n_chk = 0, n_err = 0, hs = 0;
    bit full_seen = 1'b0;

    always @(posedge clk_clk) cyc <= cyc + 1;

    always @(negedge clk_clk) begin
        if (pbuff_wren_export) wq.push_back('{int'(pb_adr_export), int'(pb_data_export), cyc});
        if (fifo_level == 3'(DEPTH)) full_seen = 1'b1;
        if (!reset_reset) begin
            n_chk++;
            if (cmd_ready !== (fifo_level != 3'(DEPTH))) begin
                n_err++;
                $display("FAIL ready_vs_level: ready=%0b level=%0d", cmd_ready, fifo_level);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected writes listed straight from the command rules: raster scan of the rectangle, clipped.
    task automatic model_add(bit op, int x, int y, int w, int h, int c);
        int ww = (FILL_EN && op) ? w : 1;
        int hh = (FILL_EN && op) ? h : 1;
        for (int j = 0; j < hh; j++)
            for (int i = 0; i < ww; i++)
                if (x + i < FB_W && y + j < FB_H) eq.push_back('{((y + j) * FB_W + x + i) % 32768, c});
    endtask

    task automatic send(bit op, int x, int y, int w, int h, int c);
        int t = 0;
        cmd_op = op; cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h); cmd_color = 4'(c);
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk_clk);
            t++;
        end
        check("send_ready", 32'(cmd_ready), 1);
        @(posedge clk_clk);
        hs = cyc + 1;
        model_add(op, x, y, w, h, c);
        @(negedge clk_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 5000) begin
            @(negedge clk_clk);
            t++;
        end
        check("idle_reached", 32'(busy), 0);
        @(negedge clk_clk);
    endtask

    task automatic cmp_queues(string name);
        check({name, "_count"}, wq.size(), eq.size());
        for (int k = 0; k < wq.size() && k < eq.size(); k++) begin
            check($sformatf("%s_adr%0d", name, k), wq[k].adr, eq[k].adr);
            check($sformatf("%s_data%0d", name, k), wq[k].data, eq[k].data);
        end
    endtask

    initial begin
        vec_t tbl[$];
        bit op;
        int x, y, w, h, c, n;
        tbl.push_back('{0, 3, 2, 0, 0, 10, 1, 323, 323});
        tbl.push_back('{0, 159, 119, 0, 0, 15, 1, 19199, 19199});
        tbl.push_back('{0, 160, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 120, 0, 0, 2, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 7, 1, 0, 0});
        tbl.push_back('{0, 255, 127, 0, 0, 3, 0, 0, 0});
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
        tbl.push_back('{1, 158, 0, 4, 2, 5, 4, 158, 319});
        tbl.push_back('{1, 0, 0, 0, 5, 1, 0, 0, 0});
        tbl.push_back('{1, 10, 10, 3, 3, 6, 9, 1610, 1932});
        tbl.push_back('{1, 250, 0, 10, 1, 4, 0, 0, 0});
        tbl.push_back('{1, 0, 126, 2, 4, 9, 0, 0, 0});
`else
        tbl.push_back('{1, 1, 1, 5, 5, 12, 1, 161, 161});
        tbl.push_back('{1, 158, 0, 4, 2, 5, 1, 158, 158});
        tbl.push_back('{1, 0, 0, 0, 0, 3, 1, 0, 0});
`endif
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        check("rst_wren", 32'(pbuff_wren_export), 0);
        check("rst_adr", 32'(pb_adr_export), 0);
        check("rst_data", 32'(pb_data_export), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_level", 32'(fifo_level), 0);
        reset_reset = 1'b0;
        @(negedge clk_clk);

        // Single pixel timing from an idle engine: strobe two cycles after the handshake, for one cycle.
        send(0, 3, 2, 0, 0, 10);
        check("px_c0_wren", 32'(pbuff_wren_export), 0);
        @(negedge clk_clk);
        check("px_c1_wren", 32'(pbuff_wren_export), 0);
        @(negedge clk_clk);
        check("px_c2_wren", 32'(pbuff_wren_export), 1);
        check("px_c2_adr", 32'(pb_adr_export), 323);
        check("px_c2_data", 32'(pb_data_export), 10);
        @(negedge clk_clk);
        check("px_c3_wren", 32'(pbuff_wren_export), 0);
        wait_idle();

        foreach (tbl[k]) begin
            wq.delete();
            send(tbl[k].op, tbl[k].x, tbl[k].y, tbl[k].w, tbl[k].h, tbl[k].c);
            wait_idle();
            check($sformatf("v%0d_count", k), wq.size(), tbl[k].n);
            if (wq.size() > 0) begin
                check($sformatf("v%0d_first", k), wq[0].adr, tbl[k].first);
                check($sformatf("v%0d_last", k), wq[wq.size() - 1].adr, tbl[k].last);
                check($sformatf("v%0d_data", k), wq[0].data, tbl[k].c);
                check($sformatf("v%0d_latency", k), wq[0].cyc - hs, 2);
            end
        end

        // Back-to-back pixels; with fill enabled a long fill first keeps the FIFO filling up.
        wq.delete(); eq.delete(); full_seen = 1'b0;
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
        send(1, 0, 0, 10, 10, 1);
`endif
        for (int k = 0; k < 5; k++) send(0, 20 + k, 50, 0, 0, k + 1);
        wait_idle();
        cmp_queues("b2b");
        n = wq.size();
        if (n >= 5)
            for (int k = n - 4; k < n; k++) check($sformatf("b2b_gap%0d", k), wq[k].cyc - wq[k - 1].cyc, 2);
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
        check("b2b_full_seen", 32'(full_seen), 1);

        // Empty fill: no strobes, busy gone two cycles after the handshake.
        wq.delete();
        send(1, 5, 5, 0, 5, 3);
        check("nop_busy0", 32'(busy), 1);
        @(negedge clk_clk);
        check("nop_busy1", 32'(busy), 1);
        @(negedge clk_clk);
        check("nop_busy2", 32'(busy), 0);
        repeat (3) @(negedge clk_clk);
        check("nop_strobes", wq.size(), 0);
`endif

        // Reset in the middle of a fill with two commands queued; cmd_valid during reset is ignored.
        send(1, 0, 0, 10, 10, 2);
        send(0, 1, 1, 0, 0, 3);
        send(0, 2, 2, 0, 0, 4);
        repeat (20) @(negedge clk_clk);
`ifdef PIXEL_WRITE_ENGINE_RECT_FILL_EN
        check("mid_level_before", 32'(fifo_level), 2);
`endif
        reset_reset = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_x = 8'd9; cmd_y = 7'd9;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        cmd_valid = 1'b0;
        check("mid_wren", 32'(pbuff_wren_export), 0);
        check("mid_level", 32'(fifo_level), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_ready", 32'(cmd_ready), 1);
        wq.delete();
        repeat (150) @(negedge clk_clk);
        check("mid_no_strobes", wq.size(), 0);

        // Randomized commands, biased toward the frame edges, against the write-list model.
        wq.delete(); eq.delete();
        for (int k = 0; k < 200; k++) begin
            op = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 159));
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 119));
            w = int'($urandom_range(0, 12));
            h = int'($urandom_range(0, 6));
            c = int'($urandom_range(0, 15));
            send(op, x, y, w, h, c);
            repeat ($urandom_range(0, 2)) @(negedge clk_clk);
        end
        wait_idle();
        cmp_queues("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pixel_write_engine.md
PIXEL_WRITE_ENGINE -- requirements
Module: pixel_write_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning pixel-buffer address width.
REQ-002 SHALL have parameter DATA_W, default 4, meaning pixel colour width.
REQ-003 SHALL have parameter FB_W, default 160, meaning frame width in pixels (row stride).
REQ-004 SHALL have parameter FB_H, default 120, meaning frame height in pixels.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of 2, >=2).
REQ-006 SHALL have parameter X_W/Y_W, default 8/7, meaning coordinate and extent widths.
REQ-007 SHALL have ports: clk_clk in 1, single clock; reset_reset in 1, synchronous active-high reset.
REQ-008 SHALL have ports: cmd_valid in 1, command offered; cmd_ready out 1, FIFO not full; cmd_op in 1, 0=pixel, 1=rect fill.
REQ-009 SHALL have ports: cmd_x in X_W; cmd_y in Y_W; cmd_w in X_W; cmd_h in Y_W; cmd_color in DATA_W.
REQ-010 SHALL have ports: pb_adr_export out ADDR_W; pb_data_export out DATA_W; pbuff_wren_export out 1, write strobe to pixel buffer.
REQ-011 SHALL have ports: busy out 1, FIFO non-empty or engine not IDLE; fifo_level out clog2(FIFO_DEPTH)+1.

Function
REQ-012 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready = (fifo_level != FIFO_DEPTH), combinational from registered state.
REQ-013 SHALL store commands in FIFO order; push while full is impossible (ready=0); push and pop in the same cycle leave fifo_level unchanged.
REQ-014 SHALL implement FSM IDLE -> LOAD -> (WRITE | FILL) -> IDLE; IDLE->LOAD when FIFO non-empty; LOAD pops head and registers it.
REQ-015 SHALL, for a pixel command, assert pbuff_wren_export for exactly one cycle; handshake in cycle n with idle engine and empty FIFO -> strobe in cycle n+2.
REQ-016 SHALL compute address = y*FB_W + x, truncated to ADDR_W bits; pb_data_export = cmd_color; all outputs registered.
REQ-017 SHALL clip: pixel with x>=FB_W or y>=FB_H produces a cycle with pbuff_wren_export=0 (no write), address/data don't-care.
REQ-018 SHALL, for a fill command, visit (x+i, y+j), i in 0..w-1 inner, j in 0..h-1 outer, one pixel per cycle, w*h cycles total, clipping per REQ-017.
REQ-019 SHALL compute x+i, y+j with one extra carry bit so coordinates past 2^X_W / 2^Y_W are clipped, never wrapped.
REQ-020 SHALL treat fill with w=0 or h=0 as a no-op: zero strobes, FSM LOAD -> IDLE.
REQ-021 SHALL hold pbuff_wren_export=0 in IDLE and LOAD; consecutive commands have exactly one non-writing LOAD cycle between them.
REQ-022 SHALL keep fifo_level accurate every cycle (0..FIFO_DEPTH).

Reset
REQ-023 SHALL, on reset_reset=1 at a clock edge, set FSM=IDLE, FIFO empty, fifo_level=0, pbuff_wren_export=0, pb_adr_export=0, pb_data_export=0, busy=0, cmd_ready=1 after that edge.
REQ-024 SHALL abort any in-progress fill and discard queued commands on reset; no strobe in the cycle following the reset edge.
REQ-025 SHALL ignore cmd_valid while reset_reset=1.

Configuration
REQ-026 SHALL use macro PIXEL_WRITE_ENGINE_RECT_FILL_EN: defined -> REQ-018..020 apply; undefined -> cmd_op=1 executed as a single pixel at (cmd_x, cmd_y), cmd_w/cmd_h ignored, fill counters not synthesised; port list identical either way.

Verification
REQ-027 SHALL cover: pixel (x=3,y=2,color=0xA) in cycle 10, idle -> cycle 12 wren=1, adr=323, data=0xA; cycle 13 wren=0.
REQ-028 SHALL cover: fill x=158,y=0,w=4,h=2,color=5 -> 8 cycles; wren=1 only at adr 158,159,318,319; 4 clipped cycles wren=0.
REQ-029 SHALL cover: 5 pixel commands offered back-to-back, FIFO_DEPTH=4, engine idle -> cmd_ready=0 once level=4; all 5 written in order, each pair separated by one LOAD cycle.
REQ-030 SHALL cover: fill w=0,h=5 -> no strobes, busy drops 2 cycles after handshake.
REQ-031 SHALL cover: reset asserted mid-way through fill w=10,h=10 with 2 queued commands -> next cycle wren=0, fifo_level=0, busy=0, no later strobes.
REQ-032 SHALL cover: macro undefined, cmd_op=1 x=1,y=1,w=5,h=5 -> exactly one strobe, adr=161.
